// File: rtl/alu_pkg.sv
// Shared ALU opcodes, datapath width and multiply-sequencer state encoding.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu.sv
// Shared 8-bit combinational ALU with carry, negative, overflow and zero flags.
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] s,
  output logic [7:0] out,
  output logic       c,
  output logic       n,
  output logic       v,
  output logic       z
);

  logic [DATA_W:0] wide;

  // Operation select; carry holds the add carry, subtract borrow or shifted-out bit.
  always_comb begin
    wide = '0;
    v    = 1'b0;
    case (s)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        v    = (a[7] == b[7]) && (wide[7] != a[7]);
      end
      ALU_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        v    = (a[7] != b[7]) && (wide[7] != a[7]);
      end
      ALU_AND: wide = {1'b0, a & b};
      ALU_OR:  wide = {1'b0, a | b};
      ALU_XOR: wide = {1'b0, a ^ b};
      ALU_NOT: wide = {1'b0, ~a};
      ALU_SHL: wide = {a, 1'b0};
      ALU_SHR: wide = {a[0], 1'b0, a[7:1]};
      default: wide = '0;
    endcase
  end

  assign out = wide[DATA_W-1:0];
  assign c   = wide[DATA_W];
  assign n   = wide[DATA_W-1];
  assign z   = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/alu_mul_ctrl.sv
// 8x8 unsigned shift-add multiplier sequenced over the shared ALU; fixed 10-cycle throughput.
module alu_mul_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        z,
  output logic        ovf8
);

  state_t     state;
  logic [7:0] mcand;
  logic [7:0] acc;
  logic [7:0] mq;
  logic [2:0] cnt;

  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_c;
  logic       alu_n;
  logic       alu_v;
  logic       alu_z;
  logic       unused_flags;

  // Add the multiplicand into the high half only when the current multiplier bit is set.
  assign alu_b = mq[0] ? mcand : 8'h00;

  alu u_alu (
    .a   (acc),
    .b   (alu_b),
    .s   (ALU_ADD),
    .out (alu_out),
    .c   (alu_c),
    .n   (alu_n),
    .v   (alu_v),
    .z   (alu_z)
  );

  assign unused_flags = ^{alu_n, alu_v, alu_z};

  // Sequencer: capture operands, run eight shift-add iterations, pulse done for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      mcand <= 8'h00;
      acc   <= 8'h00;
      mq    <= 8'h00;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= 8'h00;
            cnt   <= 3'd0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= {alu_c, alu_out[7:1]};
          mq  <= {alu_out[0], mq[7:1]};
          if (cnt == 3'd7) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign product = {acc, mq};
  assign z       = (product == 16'h0000);
  assign ovf8    = (acc != 8'h00);

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Directed self-checking bench for the shift-add multiply sequencer.
module tb_alu_mul_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        z;
  logic        ovf8;

  int errors = 0;
  int checks = 0;

  alu_mul_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .z       (z),
    .ovf8    (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples at negedges starting with the current one (the cycle right after acceptance).
  task automatic observe(input int n_samples, output int busy_n, output int done_at,
                         output int done_n, output logic [15:0] prod_d,
                         output logic z_d, output logic ovf_d);
    busy_n  = 0;
    done_at = -1;
    done_n  = 0;
    prod_d  = 16'hxxxx;
    z_d     = 1'bx;
    ovf_d   = 1'bx;
    for (int k = 0; k < n_samples; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = k;
          prod_d  = product;
          z_d     = z;
          ovf_d   = ovf8;
        end
      end
    end
  endtask

  task automatic launch(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int          busy_n;
  int          done_at;
  int          done_n;
  int          lat_ff;
  logic [15:0] prod_d;
  logic        z_d;
  logic        ovf_d;
  int          dtimes[4];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    // Reset values while held in reset and after release.
    repeat (2) @(negedge clk);
    chk("rst_product", 32'(product), 32'h0000);
    chk("rst_z", 32'(z), 32'd1);
    chk("rst_ovf8", 32'(ovf8), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_product", 32'(product), 32'h0000);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // 13 x 11 = 143.
    launch(8'd13, 8'd11);
    observe(15, busy_n, done_at, done_n, prod_d, z_d, ovf_d);
    chk("13x11_busy_cycles", 32'(busy_n), 32'd8);
    chk("13x11_done_at", 32'(done_at), 32'd8);
    chk("13x11_done_count", 32'(done_n), 32'd1);
    chk("13x11_product", 32'(prod_d), 32'h008F);
    chk("13x11_z", 32'(z_d), 32'd0);
    chk("13x11_ovf8", 32'(ovf_d), 32'd0);
    chk("13x11_hold", 32'(product), 32'h008F);

    // Largest operands.
    launch(8'hFF, 8'hFF);
    observe(15, busy_n, done_at, done_n, prod_d, z_d, ovf_d);
    lat_ff = done_at;
    chk("ffxff_product", 32'(prod_d), 32'hFE01);
    chk("ffxff_ovf8", 32'(ovf_d), 32'd1);
    chk("ffxff_z", 32'(z_d), 32'd0);
    chk("ffxff_done_at", 32'(done_at), 32'd8);

    // Zero multiplicand; same latency as the all-ones case.
    launch(8'h00, 8'hA5);
    observe(15, busy_n, done_at, done_n, prod_d, z_d, ovf_d);
    chk("0xa5_product", 32'(prod_d), 32'h0000);
    chk("0xa5_z", 32'(z_d), 32'd1);
    chk("0xa5_ovf8", 32'(ovf_d), 32'd0);
    chk("0xa5_same_latency", 32'(done_at), 32'(lat_ff));

    // Start held high: re-accepted only from IDLE, operand wiggle mid-RUN ignored.
    @(negedge clk);
    a     = 8'd3;
    b     = 8'd5;
    start = 1'b1;
    @(negedge clk);
    done_n = 0;
    for (int k = 0; k < 31; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) begin a = 8'hFF; b = 8'hFF; end
      if (k == 7) begin a = 8'd3;  b = 8'd5;  end
      if (done) begin
        if (done_n < 4) dtimes[done_n] = k;
        done_n++;
        chk("held_product", 32'(product), 32'd15);
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_n), 32'd3);
    chk("held_first_done", 32'(dtimes[0]), 32'd8);
    chk("held_spacing_1", 32'(dtimes[1] - dtimes[0]), 32'd10);
    chk("held_spacing_2", 32'(dtimes[2] - dtimes[1]), 32'd10);
    repeat (12) @(negedge clk);
    chk("held_drain_busy", 32'(busy), 32'd0);

    // Start pulses during RUN and DONE are ignored.
    launch(8'd200, 8'd2);
    done_n = 0;
    prod_d = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) begin start = 1'b1; a = 8'd1; b = 8'd1; end
      if (k == 5) start = 1'b0;
      if (k == 8) start = 1'b1;
      if (k == 9) start = 1'b0;
      if (done) begin
        done_n++;
        prod_d = product;
      end
    end
    chk("ignore_done_count", 32'(done_n), 32'd1);
    chk("ignore_product", 32'(prod_d), 32'h0190);
    chk("ignore_hold", 32'(product), 32'h0190);
    chk("ignore_busy", 32'(busy), 32'd0);

    // Reset mid-RUN aborts the operation immediately.
    launch(8'd100, 8'd100);
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'h0000);
    chk("abort_z", 32'(z), 32'd1);
    chk("abort_ovf8", 32'(ovf8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    observe(12, busy_n, done_at, done_n, prod_d, z_d, ovf_d);
    chk("abort_no_done", 32'(done_n), 32'd0);
    chk("abort_no_busy", 32'(busy_n), 32'd0);

    // Start presented together with reset release is honoured at the first edge.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a     = 8'd100;
    b     = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    observe(15, busy_n, done_at, done_n, prod_d, z_d, ovf_d);
    chk("rerun_done_at", 32'(done_at), 32'd8);
    chk("rerun_product", 32'(prod_d), 32'h2710);
    chk("rerun_ovf8", 32'(ovf_d), 32'd1);
    chk("rerun_busy_cycles", 32'(busy_n), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mul_ctrl.md
# alu_mul_ctrl

Multi-cycle sequencer that computes an 8×8 unsigned multiply by driving the shared 8-bit `alu` through a shift-add loop, one multiplier bit per cycle. It sits between the register-file/decode side and the `alu`. It accepts operands with a start pulse, holds the `alu` select at ADD for the whole run, and returns a 16-bit product with a one-cycle done pulse. Latency is fixed and data-independent.

## Interface
- No parameters; width fixed at 8-bit operands / 16-bit product, matching `alu`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  8  multiplicand; captured when `start` is accepted.
- `b`  in  8  multiplier; captured when `start` is accepted.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; product valid.
- `product`  out  16  unsigned a×b; holds until the next accepted start.
- `z`  out  1  product == 0; valid with `done` and holds with `product`.
- `ovf8`  out  1  product[15:8] != 0; the result does not fit 8 bits.

## Operation
- Registers:
  - `mcand[7:0]`
  - `acc[7:0]` (product high half)
  - `mq[7:0]` (multiplier, then product low half)
  - `cnt[2:0]`
  - `state`
- `product` = {acc, mq}. `z` and `ovf8` are derived combinationally from it.
- States:
  - IDLE: if `start`=1 at the edge, load `mcand`←a, `mq`←b, `acc`←0, `cnt`←0 → RUN. Otherwise stay in IDLE.
  - RUN: each edge performs one iteration. When `cnt`==7, go → DONE. Otherwise `cnt`←`cnt`+1.
  - DONE: `done`=1 for this single cycle; next edge → IDLE unconditionally.
- Iteration using the `alu` instance:
  - Inputs: alu.a=`acc`, alu.b = `mq[0]` ? `mcand` : 8'h00, alu.s=3'b000 (ADD).
  - Next state: `acc`←{alu.c, alu.out[7:1]}, `mq`←{alu.out[0], mq[7:1]}.
  - The 9-bit {c,out} sum never overflows the 16-bit result.
- The `alu` is driven with s=ADD and the same operand muxing in all states. Outputs are used only in RUN. `alu` flags n/v/z are ignored.
- `start` in RUN or DONE is ignored; it is not queued.
- Operand changes on `a`/`b` after acceptance have no effect.

## Timing
- Reset (async assert, any state, including mid-RUN):
  - state=IDLE, `busy`=0, `done`=0, `acc`=`mq`=`mcand`=0, `cnt`=0.
  - Hence `product`=0, `z`=1, `ovf8`=0.
  - The aborted operation is lost.
- Start accepted at edge E0. RUN spans cycles E0..E8; iterations occur at edges E1..E8.
- `busy` is high for exactly 8 cycles.
- DONE occupies cycle E8..E9: `done`=1, `product` final.
- Earliest next accept is edge E10: at E9 the block re-enters IDLE, and `start` is sampled at edge E10. That gives a throughput of 1 product per 10 cycles.
- `product` is intermediate (not meaningful) while `busy`=1. Consumers use it only on `done` or afterwards while IDLE.
- Simultaneous `start` and reset deassertion: start is honoured at the first edge with `rst_n`=1.

## Structure
- Shared package (`alu_pkg`):
  - ALU opcode constants: ALU_ADD=3'b000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_NOT=101, ALU_SHL=110, ALU_SHR=111.
  - Sequencer state type: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- One sub-module: the existing `alu`, instantiated once and named `u_alu`. No other hierarchy.
- Unused state encoding 2'b11 → IDLE on the next edge.

## Test plan
- Reset then idle: `product`=16'h0000, `z`=1, `ovf8`=0, `busy`=0, `done`=0.
- a=13, b=11, start one cycle:
  - `busy` high exactly 8 cycles.
  - `done` pulses once in the 9th cycle after acceptance.
  - `product`=16'h008F, `z`=0, `ovf8`=0.
- a=8'hFF, b=8'hFF: `product`=16'hFE01, `ovf8`=1. Then a=0, b=8'hA5: `product`=0, `z`=1. Latency is identical for both (data-independent).
- Start held high continuously with a=3, b=5: `product`=15.
  - Re-accepted only at each IDLE, so `done` pulses are exactly 10 cycles apart.
  - Operand changes mid-RUN do not alter the result.
- Start pulse during RUN and during DONE: ignored, no extra `done`, and the result of the first operation (a=200, b=2 → 16'h0190) is unchanged.
- `rst_n` asserted at RUN cycle 4 of a=100, b=100: all outputs return to reset values immediately and no `done` appears. A subsequent start with a=100, b=100 yields 16'h2710.
